// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, FSM states and wait limits for the load/store unit
package lsu_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // Legal range of memory read wait cycles
  localparam int READ_WAIT_MIN = 1;
  localparam int READ_WAIT_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_e;

  // Halfwords need an even address, words a multiple of four, size 11 never works
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = offset[0];
      SIZE_WORD: mis = (offset != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - big-endian lane extraction and sub-word merge
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_unsigned,
  input  logic [31:0] i_word,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  // Offset 0 is the most significant lane, so the shift is (3 - offset) lanes
  logic [4:0]  w_byte_sh;
  logic [4:0]  w_half_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte_sh = {~i_offset, 3'b000};
  assign w_half_sh = {~i_offset[1], 4'b0000};
  assign w_byte    = 8'(i_word >> w_byte_sh);
  assign w_half    = 16'(i_word >> w_half_sh);

  // Extend the addressed lane for loads and splice new data in for stores
  always_comb begin
    o_load_data = i_word;
    o_merged    = i_word;
    case (i_size)
      SIZE_BYTE: begin
        o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
        o_merged    = (i_word & ~(32'h0000_00FF << w_byte_sh)) |
                      ({24'h0, i_wdata[7:0]} << w_byte_sh);
      end
      SIZE_HALF: begin
        o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
        o_merged    = (i_word & ~(32'h0000_FFFF << w_half_sh)) |
                      ({16'h0, i_wdata} << w_half_sh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit over a word memory; LSU_ALIGN_CHECK_EN enables fault detection
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int READ_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int RW_EFF = (READ_WAIT < READ_WAIT_MIN) ? READ_WAIT_MIN :
                          (READ_WAIT > READ_WAIT_MAX) ? READ_WAIT_MAX : READ_WAIT;
  localparam logic [2:0] WAIT_INIT = 3'(RW_EFF - 1);

  lsu_state_e  r_state;
  lsu_state_e  w_next_state;
  logic        r_write;
  logic        r_unsigned;
  logic        r_misaligned;
  logic [1:0]  r_size;
  logic [1:0]  r_offset;
  logic [29:0] r_word_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdword;
  logic [2:0]  r_wait_cnt;
  logic [1:0]  w_eff_size;
  logic [1:0]  w_eff_offset;
  logic        w_req_mis;
  logic        w_accept;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign w_accept = (r_state == ST_IDLE) && req_valid;

  // Normalise the incoming size/offset and flag faults
  always_comb begin
    w_eff_size   = req_size;
    w_eff_offset = req_addr[1:0];
    w_req_mis    = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    w_req_mis    = is_misaligned(req_size, req_addr[1:0]);
`else
    if (req_size == SIZE_ILLEGAL) w_eff_size = SIZE_WORD;
    if (w_eff_size == SIZE_HALF) w_eff_offset[0] = 1'b0;
    else if (w_eff_size == SIZE_WORD) w_eff_offset = 2'b00;
`endif
  end

  lsu_lane_align u_lane_align (
    .i_size      (r_size),
    .i_offset    (r_offset),
    .i_unsigned  (r_unsigned),
    .i_word      (r_rdword),
    .i_wdata     (r_wdata[15:0]),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_req_mis)                                   w_next_state = ST_RESP;
          else if (req_write && w_eff_size == SIZE_WORD)   w_next_state = ST_WR;
          else                                             w_next_state = ST_RD;
        end
      end
      ST_RD:   if (r_wait_cnt == 3'd0) w_next_state = r_write ? ST_WR : ST_RESP;
      ST_WR:   w_next_state = ST_RESP;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Capture the request at acceptance and the memory word at the end of RD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write      <= 1'b0;
      r_unsigned   <= 1'b0;
      r_misaligned <= 1'b0;
      r_size       <= SIZE_BYTE;
      r_offset     <= 2'b00;
      r_word_addr  <= '0;
      r_wdata      <= '0;
      r_rdword     <= '0;
      r_wait_cnt   <= '0;
    end else if (w_accept) begin
      r_write      <= req_write;
      r_unsigned   <= req_unsigned;
      r_misaligned <= w_req_mis;
      r_size       <= w_eff_size;
      r_offset     <= w_eff_offset;
      r_word_addr  <= req_addr[31:2];
      r_wdata      <= req_wdata;
      r_wait_cnt   <= WAIT_INIT;
    end else if (r_state == ST_RD) begin
      if (r_wait_cnt == 3'd0) r_rdword   <= mem_read_data;
      else                    r_wait_cnt <= r_wait_cnt - 3'd1;
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    req_ready       = (r_state == ST_IDLE);
    resp_valid      = (r_state == ST_RESP);
    resp_misaligned = resp_valid && r_misaligned;
    resp_rdata      = (resp_valid && !r_write && !r_misaligned) ? w_load_data : 32'h0;
    mem_address     = {r_word_addr, 2'b00};
    mem_write       = (r_state == ST_WR);
    mem_write_data  = 32'h0;
    if (mem_write) mem_write_data = (r_size == SIZE_WORD) ? r_wdata : w_merged;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized and directed checks of load_store_unit against a behavioural model
module tb_load_store_unit;

  localparam int RW1 = 1;
  localparam int RW3 = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_misaligned, mem_write;
  logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;

  logic        req_valid3 = 1'b0, req_write3 = 1'b0, req_unsigned3 = 1'b0;
  logic [1:0]  req_size3 = 2'b00;
  logic [31:0] req_addr3 = 32'h0, req_wdata3 = 32'h0;
  logic        req_ready3, resp_valid3, resp_misaligned3, mem_write3;
  logic [31:0] resp_rdata3, mem_address3, mem_write_data3, mem_read_data3;

  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] mem3 [0:15];

  int n_checks = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  logic [31:0] last_wdata = 32'h0;

  always #5 clk = ~clk;

  load_store_unit #(.READ_WAIT(RW1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
    .mem_address(mem_address), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  load_store_unit #(.READ_WAIT(RW3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_write(req_write3), .req_size(req_size3), .req_unsigned(req_unsigned3),
    .req_addr(req_addr3), .req_wdata(req_wdata3), .resp_valid(resp_valid3),
    .resp_rdata(resp_rdata3), .resp_misaligned(resp_misaligned3),
    .mem_address(mem_address3), .mem_write(mem_write3),
    .mem_write_data(mem_write_data3), .mem_read_data(mem_read_data3)
  );

  assign mem_read_data  = mem[mem_address[9:2]];
  assign mem_read_data3 = mem3[mem_address3[5:2]];

  always @(posedge clk) if (mem_write) mem[mem_address[9:2]] = mem_write_data;

  always @(negedge clk) if (mem_write) begin
    wr_cnt = wr_cnt + 1;
    last_wdata = mem_write_data;
  end

  task automatic set_word(input int idx, input logic [31:0] val);
    mem[idx] = val;
    ref_mem[idx] = val;
  endtask

  // Architectural result of one request: lane arithmetic on the big-endian word
  task automatic model(input logic w, input logic [1:0] sz, input logic un, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] word, input int rw,
                       output logic [31:0] rd, output logic [31:0] nw, output logic mis,
                       output int lat, output int nwr);
    int nb, off;
    longint mask, sh, val;
    nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off = int'(a[1:0]);
    mis = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`else
    off = (off / nb) * nb;
`endif
    if (mis) off = 0;
    sh   = 8 * (4 - off - nb);
    mask = (64'd1 << (8 * nb)) - 1;
    val  = (longint'(word) >> sh) & mask;
    if (!un && nb < 4 && ((val >> (8 * nb - 1)) & 1) == 1) val = val | ~mask;
    rd = 32'h0; nw = word; nwr = 0;
    if (mis) lat = 1;
    else if (!w) begin
      rd  = 32'(val);
      lat = rw + 1;
    end else begin
      nw  = 32'((longint'(word) & ~(mask << sh)) | ((longint'(wd) & mask) << sh));
      nwr = 1;
      lat = (nb == 4) ? 2 : rw + 2;
    end
  endtask

  // One request on the READ_WAIT=1 unit, checked against the model; called at a negedge
  task automatic do_txn(input logic w, input logic [1:0] sz, input logic un, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, input string tag,
                        output int waited, output logic [31:0] got_rd, output int got_lat,
                        output logic got_mis);
    logic [31:0] e_rd, e_nw;
    logic e_mis, ok;
    int e_lat, e_nwr, wr0, idx;
    idx = int'(a[9:2]);
    model(w, sz, un, a, wd, ref_mem[idx], RW1, e_rd, e_nw, e_mis, e_lat, e_nwr);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd;
    waited = 0; got_rd = 32'h0; got_lat = 0; got_mis = 1'b0; ok = 1'b0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (!req_ready) begin
      n_fail++;
      $display("FAIL %s accept: req_ready=%0b after %0d cycles, required 1", tag, req_ready, waited);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    wr0 = wr_cnt;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) req_valid = 1'b0;
      if (resp_valid) begin
        got_lat = k; got_rd = resp_rdata; got_mis = resp_misaligned; ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s resp_timeout: no resp_valid within 20 cycles, required latency %0d", tag, e_lat);
      return;
    end
    n_checks++;
    if (got_lat !== e_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d required %0d", tag, got_lat, e_lat);
    end
    n_checks++;
    if (got_rd !== e_rd) begin
      n_fail++;
      $display("FAIL %s rdata: got %08h required %08h", tag, got_rd, e_rd);
    end
    n_checks++;
    if (got_mis !== e_mis) begin
      n_fail++;
      $display("FAIL %s misaligned: got %0b required %0b", tag, got_mis, e_mis);
    end
    n_checks++;
    if (wr_cnt - wr0 != e_nwr) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d required %0d", tag, wr_cnt - wr0, e_nwr);
    end
    ref_mem[idx] = e_nw;
    n_checks++;
    if (mem[idx] !== e_nw) begin
      n_fail++;
      $display("FAIL %s mem_word: got %08h required %08h", tag, mem[idx], e_nw);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready, resp_valid, resp_misaligned, mem_write} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: ready/valid/mis/wr got %04b required 1000",
               {req_ready, resp_valid, resp_misaligned, mem_write});
    end
    n_checks++;
    if ({resp_rdata, mem_address, mem_write_data} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%08h addr=%08h wdata=%08h required all 0",
               resp_rdata, mem_address, mem_write_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_byte_load();
    int wt, lt; logic [31:0] rd; logic ms;
    set_word(4, 32'h8899AABB);
    do_txn(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, "lb_signed", wt, rd, lt, ms);
    n_checks++;
    if (rd !== 32'hFFFFFF99 || lt != 2) begin
      n_fail++;
      $display("FAIL lb_signed_fixed: got %08h@%0d required ffffff99@2", rd, lt);
    end
    do_txn(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, "lbu", wt, rd, lt, ms);
    n_checks++;
    if (rd !== 32'h00000099) begin
      n_fail++;
      $display("FAIL lbu_fixed: got %08h required 00000099", rd);
    end
  endtask

  task automatic test_byte_store();
    int wt, lt, w0; logic [31:0] rd; logic ms;
    set_word(4, 32'h8899AABB);
    w0 = wr_cnt;
    do_txn(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000005A, 1'b0, "sb", wt, rd, lt, ms);
    n_checks++;
    if (last_wdata !== 32'h88995ABB || lt != 3 || wr_cnt - w0 != 1) begin
      n_fail++;
      $display("FAIL sb_fixed: wdata=%08h lat=%0d writes=%0d required 88995abb 3 1",
               last_wdata, lt, wr_cnt - w0);
    end
  endtask

  task automatic test_misaligned();
    int wt, lt; logic [31:0] rd; logic ms;
    set_word(8'h40, 32'h13579BDF);
    do_txn(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b0, "lw_102", wt, rd, lt, ms);
    do_txn(1'b1, 2'b01, 1'b0, 32'h103, 32'h1234ABCD, 1'b0, "sh_103", wt, rd, lt, ms);
    do_txn(1'b0, 2'b11, 1'b1, 32'h100, 32'h0, 1'b0, "size11", wt, rd, lt, ms);
  endtask

  task automatic test_back_to_back();
    int wt, lt; logic [31:0] rd; logic ms;
    do_txn(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 1'b1, "b2b_sw", wt, rd, lt, ms);
    do_txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, "b2b_lw", wt, rd, lt, ms);
    n_checks++;
    if (wt != 1 || rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL b2b_fixed: wait=%0d rdata=%08h required 1 deadbeef", wt, rd);
    end
  endtask

  task automatic test_readwait3();
    logic [31:0] e_rd, e_nw, rd; logic e_mis, ok; int e_lat, e_nwr, lt;
    mem3[0] = 32'h80011234;
    model(1'b0, 2'b01, 1'b0, 32'h0, 32'h0, mem3[0], RW3, e_rd, e_nw, e_mis, e_lat, e_nwr);
    req_valid3 = 1'b1; req_write3 = 1'b0; req_size3 = 2'b01; req_unsigned3 = 1'b0; req_addr3 = 32'h0;
    @(posedge clk);
    ok = 1'b0; lt = 0; rd = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) req_valid3 = 1'b0;
      n_checks++;
      if (mem_write3 !== 1'b0) begin
        n_fail++;
        $display("FAIL rw3_no_write: mem_write=%0b required 0", mem_write3);
      end
      if (resp_valid3) begin lt = k; rd = resp_rdata3; ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok || lt != e_lat || lt != 4 || rd !== e_rd || rd !== 32'hFFFF8001) begin
      n_fail++;
      $display("FAIL rw3_lh: got %08h@%0d required ffff8001@4", rd, lt);
    end
  endtask

  task automatic test_random();
    int wt, lt; logic [31:0] rd; logic ms;
    for (int i = 0; i < 256; i++) set_word(i, $urandom);
    for (int i = 0; i < 60; i++) begin
      do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 1023)), $urandom, 1'($urandom_range(0, 1)), "rand",
             wt, rd, lt, ms);
      req_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_reset_abort();
    logic seen;
    set_word(12, 32'hCAFEF00D);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h32; req_wdata = 32'h00001111;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_write) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL abort_reach_wr: mem_write never seen, required 1");
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_write !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_async: mem_write=%0b req_ready=%0b required 0 1", mem_write, req_ready);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      n_checks++;
      if (resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_resp: resp_valid=%0b required 0", resp_valid);
      end
    end
    n_checks++;
    if (mem[12] !== ref_mem[12]) begin
      n_fail++;
      $display("FAIL abort_mem: got %08h required %08h", mem[12], ref_mem[12]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) set_word(i, 32'h0);
    for (int i = 0; i < 16; i++) mem3[i] = 32'h0;
    test_reset();
    test_byte_load();
    test_byte_store();
    test_misaligned();
    test_back_to_back();
    test_readwait3();
    test_random();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
